// File: rtl/rv32i_types.sv
// Shared types for the direct-mapped data cache: FSM states, address field widths
// and the captured request payload.
package rv32i_types;

  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned WORD_SEL_W = 3;
  localparam int unsigned INDEX_W    = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } dcache_state_t;

  // Word address (byte address >> 2) plus the write side of the request.
  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dcache_req_t;

endpackage

// File: rtl/dcache_array.sv
// Flop-based storage for the direct-mapped cache: valid/dirty/tag/line per set,
// combinational read, byte-enabled word write and full-line fill.
module dcache_array
  import rv32i_types::*;
#(
  parameter int unsigned SETS      = 16,
  parameter int unsigned TAG_W     = 23,
  parameter int unsigned LINE_BITS = 256,
  localparam int unsigned IDX_W    = $clog2(SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_BITS-1:0]  rd_line,
  input  logic                  word_we,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [3:0]            word_bmask,
  input  logic [31:0]           word_data,
  input  logic                  line_we,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic [LINE_BITS-1:0]  line_data,
  input  logic                  dirty_clr
);

  logic [SETS-1:0]      valid;
  logic [SETS-1:0]      dirty;
  logic [TAG_W-1:0]     tags [SETS];
  logic [LINE_BITS-1:0] data [SETS];

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_line  = data[idx];

  // Status bits: a fill leaves the line clean, a word write dirties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_we) begin
      dirty[idx] <= 1'b1;
    end else if (dirty_clr) begin
      dirty[idx] <= 1'b0;
    end
  end

  // Tag and data carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tags[idx] <= line_tag;
      data[idx] <= line_data;
    end else if (word_we) begin
      for (int b = 0; b < 4; b++) begin
        if (word_bmask[b]) begin
          data[idx][{word_sel, 2'(b), 3'b000} +: 8] <= word_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with 32-byte lines in front
// of a line-wide backing memory port.
module dcache_dm
  import rv32i_types::*;
#(
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_BYTES = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               dmem_addr,
  input  logic [3:0]                dmem_rmask,
  input  logic [3:0]                dmem_wmask,
  input  logic [31:0]               dmem_wdata,
  output logic [31:0]               dmem_rdata,
  output logic                      dmem_resp,
  output logic [31:0]               dfp_addr,
  output logic                      dfp_read,
  output logic                      dfp_write,
  input  logic [8*LINE_BYTES-1:0]   dfp_rdata,
  output logic [8*LINE_BYTES-1:0]   dfp_wdata,
  input  logic                      dfp_resp
);

  localparam int unsigned IDX_W     = $clog2(SETS);
  localparam int unsigned TAG_W     = 32 - OFFSET_W - IDX_W;
  localparam int unsigned LINE_BITS = 8 * LINE_BYTES;

  dcache_state_t state, state_next;
  dcache_req_t   req_q;
  logic          capture;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [WORD_SEL_W-1:0] word_sel;
  logic                  rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_BITS-1:0]  rd_line;
  logic                  word_we, line_we, dirty_clr;

  assign idx      = req_q.waddr[OFFSET_W-2 +: IDX_W];
  assign tag      = req_q.waddr[29 -: TAG_W];
  assign word_sel = req_q.waddr[WORD_SEL_W-1:0];
  assign hit      = rd_valid && (rd_tag == tag);

  dcache_array #(
    .SETS      (SETS),
    .TAG_W     (TAG_W),
    .LINE_BITS (LINE_BITS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .word_we    (word_we),
    .word_sel   (word_sel),
    .word_bmask (req_q.wmask),
    .word_data  (req_q.wdata),
    .line_we    (line_we),
    .line_tag   (tag),
    .line_data  (dfp_rdata),
    .dirty_clr  (dirty_clr)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The request is held in req_q so later dmem_* changes are ignored until IDLE.
  always_ff @(posedge clk) begin
    if (capture) begin
      req_q.waddr <= dmem_addr[31:2];
      req_q.wmask <= dmem_wmask;
      req_q.wdata <= dmem_wdata;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    word_we    = 1'b0;
    line_we    = 1'b0;
    dirty_clr  = 1'b0;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    dfp_read   = 1'b0;
    dfp_write  = 1'b0;
    dfp_addr   = '0;
    dfp_wdata  = '0;
    unique case (state)
      IDLE: begin
        if ((|dmem_rmask) || (|dmem_wmask)) begin
          capture    = 1'b1;
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          dmem_resp  = 1'b1;
          word_we    = |req_q.wmask;
          state_next = IDLE;
        end else if (rd_valid && rd_dirty) begin
          state_next = WRITEBACK;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITEBACK: begin
        dfp_write = 1'b1;
        dfp_addr  = {rd_tag, idx, 5'b00000};
        dfp_wdata = rd_line;
        if (dfp_resp) begin
          dirty_clr  = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        dfp_read = 1'b1;
        dfp_addr = {tag, idx, 5'b00000};
        if (dfp_resp) begin
          line_we    = 1'b1;
          state_next = COMPARE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A reset in the completing cycle must not leak a response.
    if (rst) dmem_resp = 1'b0;
    if (dmem_resp) dmem_rdata = rd_line[{word_sel, 5'b00000} +: 32];
  end

endmodule

// File: doc/dcache_dm.md
DCACHE_DM -- requirements
Module: dcache_dm

Interface
REQ-001 SHALL have parameter SETS, default 16, number of direct-mapped sets (power of two).
REQ-002 SHALL have parameter LINE_BYTES, default 32, bytes per line (fixed at 32 for this revision).
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port dmem_addr  input  32  request byte address; bits [1:0] ignored.
REQ-006 SHALL have port dmem_rmask  input  4  byte read mask; nonzero means read request.
REQ-007 SHALL have port dmem_wmask  input  4  byte write mask; nonzero means write request.
REQ-008 SHALL have port dmem_wdata  input  32  write data, byte lanes aligned to the mask.
REQ-009 SHALL have port dmem_rdata  output  32  full aligned word; valid only while dmem_resp=1.
REQ-010 SHALL have port dmem_resp  output  1  one-cycle completion pulse.
REQ-011 SHALL have port dfp_addr  output  32  line address, bits [4:0]=0.
REQ-012 SHALL have ports dfp_read / dfp_write  output  1 each  backing-memory read and write requests.
REQ-013 SHALL have ports dfp_rdata  input  256  fill line, and dfp_wdata  output  256  victim line.
REQ-014 SHALL have port dfp_resp  input  1  one-cycle backing-memory completion.

Function
REQ-015 SHALL decode the address as offset [4:0], word [4:2], index [4+log2(SETS):5], and tag as the remaining upper bits.
REQ-016 SHALL hold, per set, flop-based valid, dirty, tag and 256-bit data, readable combinationally.
REQ-017 SHALL implement the FSM states IDLE, COMPARE, WRITEBACK and ALLOCATE.
REQ-018 SHALL, in IDLE with |rmask or |wmask, register addr/masks/wdata and move to COMPARE; with no request it SHALL stay in IDLE.
REQ-019 SHALL, in COMPARE on a hit (valid and tag equal), assert dmem_resp for exactly one cycle, drive the stored word, and return to IDLE.
REQ-020 SHALL, on a write hit, merge only the wmask bytes into the word at the same edge as dmem_resp and set dirty; dmem_rdata SHALL show the pre-write word.
REQ-021 SHALL make hit latency 2 cycles: request sampled in cycle N, dmem_resp in cycle N+1.
REQ-022 SHALL, on a miss with the victim clean or invalid, go to ALLOCATE; with the victim valid and dirty, it SHALL go to WRITEBACK.
REQ-023 SHALL, in WRITEBACK, hold dfp_write=1 with dfp_addr={victim tag, index, 5'b0} and dfp_wdata=victim line stable until dfp_resp, then clear dirty and go to ALLOCATE.
REQ-024 SHALL, in ALLOCATE, hold dfp_read=1 with dfp_addr=request line address until dfp_resp, then write the line, tag, valid=1 and dirty=0, and return to COMPARE so the request completes as a hit.
REQ-025 SHALL never assert dfp_read and dfp_write together, and SHALL never assert dmem_resp outside COMPARE.
REQ-026 SHALL ignore dmem_* input changes outside IDLE; the initiator holds the request until dmem_resp and drops its masks the cycle after.
REQ-027 SHALL treat rmask and wmask both nonzero as a write.
REQ-028 SHALL ignore dfp_resp while neither dfp_read nor dfp_write is asserted.

Reset
REQ-029 SHALL, on rst, set state to IDLE, clear all valid and dirty bits, and drive dmem_resp, dfp_read and dfp_write to 0 and dfp_addr, dfp_wdata and dmem_rdata to 0; tag and data arrays need not reset.
REQ-030 SHALL, on rst mid-operation, drop dfp_read/dfp_write in the following cycle, issue no pending dmem_resp, and discard any late dfp_resp.

Structure
REQ-031 SHALL place the dcache_state_t enum and the offset/index widths in rv32i_types.
REQ-032 SHALL use one sub-module, dcache_array (valid/dirty/tag/data storage with a byte-enabled word write and a full-line write), instantiated once.

Verification
REQ-033 SHALL cover: after reset, read 0x00001004 rmask 1111 -> dfp_read with dfp_addr 0x00001000; return a line with word1=0xDEADBEEF -> dmem_resp with rdata 0xDEADBEEF.
REQ-034 SHALL cover: then write 0x00001004 wmask 0010 wdata 0x0000AB00 -> dmem_resp 1 cycle after the request, no dfp traffic; a subsequent read returns 0xDEADABEF.
REQ-035 SHALL cover: then read 0x00001204 (same index, different tag) -> dfp_write addr 0x00001000 with word1=0xDEADABEF, then dfp_read addr 0x00001200, then dmem_resp.
REQ-036 SHALL cover: dfp_resp delayed 10 cycles -> dfp_read and dfp_addr stable for all 10 cycles, dmem_resp=0 throughout.
REQ-037 SHALL cover: rst asserted during ALLOCATE -> dfp_read=0 next cycle, no dmem_resp; a re-read of the same address misses.
